keypad_encoder: RTL
===================

# keypad_encoder

Transmit side of the keypad-to-checker link. Samples four raw digit buttons and one enter button, synchronizes and debounces them, and emits one `input_value` strobe per accepted press with the 2-bit digit code on `bits`. Also emits a one-cycle `compare` pulse on enter and reports the digit count as `pw_length`. Sits between the board buttons and `code_checker`.

## Interface
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable synchronized cycles required to accept a level change (10 ms at 50 MHz); minimum 2.
- `MAX_DIGITS`, default 4: saturation value of `pw_length`.
- `REPEAT_CYCLES`, default 25000000: auto-repeat period; used only when auto-repeat is compiled in.
- `clk` in 1: single clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-high; sampled on `clk`.
- `key` in 4: raw digit buttons, active-high, asynchronous; `key[i]` encodes digit `i`.
- `enter` in 1: raw enter button, active-high, asynchronous.
- `clear` in 1: synchronous pulse; zeroes `pw_length`.
- `input_value` out 1: one-cycle strobe per accepted digit.
- `bits` out 2: digit code; valid in the `input_value` cycle and held until the next strobe.
- `compare` out 1: one-cycle pulse per accepted enter press.
- `pw_length` out 3: digits accepted since reset or `clear`; saturates at `MAX_DIGITS`.

## Operation
- Each of the five lines passes through a 2-FF synchronizer, then a debouncer. The debounced level changes only after the synchronized level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles. Any bounce restarts the count.
- The digit FSM (`IDLE`, `PRESSED`, `LOCKOUT`) runs on debounced `key`:
  - `IDLE`: exactly one debounced key high → strobe `input_value`, load `bits`, go to `PRESSED`. Two or more high → go to `LOCKOUT` with no strobe.
  - `PRESSED`: another key also goes high → `LOCKOUT`. All keys low → `IDLE`.
  - `LOCKOUT`: all keys low → `IDLE`. No strobes are issued in this state.
- Enter has no FSM. A rising edge of debounced `enter` pulses `compare` for one cycle. Enter is independent of the digit keys.
- `pw_length` increments on each `input_value` strobe and saturates at `MAX_DIGITS`. Strobes continue past saturation.
- `clear` zeroes `pw_length` but does not affect the FSM or the debouncers.
- Same-cycle `clear` and strobe: `pw_length` becomes 1.
- Reset values: all outputs 0. FSM in `IDLE`, synchronizers and debounced levels 0, counters 0.
- Reset mid-press with the key still held: after reset the debounced level re-rises from 0, so a new strobe follows `DEBOUNCE_CYCLES` later. This is intended behaviour.

## Timing
- Latency from a clean raw rising edge on a key to `input_value`: 2 synchronizer cycles plus `DEBOUNCE_CYCLES`, plus 1 registered output cycle. `input_value` is high during cycle 3 + `DEBOUNCE_CYCLES` after the edge.
- `compare` has identical latency relative to `enter`.
- Release is debounced with the same delay. A new press is accepted only after `IDLE` is re-entered.
- All outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- `KEYPAD_ENCODER_AUTOREPEAT_EN` defined:
  - In `PRESSED`, a repeat counter re-strobes `input_value` with the same `bits` every `REPEAT_CYCLES` cycles while the single key stays held. Each repeat increments `pw_length`.
  - The counter clears on entry to `PRESSED`.
- Undefined: exactly one strobe per press. The repeat counter and `REPEAT_CYCLES` logic are absent.

## Structure
- Shared package `keypad_pkg` holds:
  - `KEY_CODE_W = 2` and `NUM_KEYS = 4`;
  - the FSM state enum (`IDLE`, `PRESSED`, `LOCKOUT`);
  - the one-hot-to-code function used to form `bits`.
- Sub-module `keypad_debounce` (one line: synchronizer plus debounce counter, parameter `DEBOUNCE_CYCLES`) is instantiated five times.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `MAX_DIGITS = 4`, `REPEAT_CYCLES = 8`.
- Clean press of `key[2]`, held 20 cycles: `input_value` high for exactly 1 cycle, 7 cycles after the edge, with `bits = 2'd2` and `pw_length = 1`. No further strobe while held (repeat undefined).
- `key[1]` toggling every 2 cycles for 12 cycles, then held: no strobe during the bounce. One strobe 7 cycles after the last edge, with `bits = 2'd1`.
- `key[0]` and `key[3]` pressed together, then released: zero strobes and `pw_length` unchanged. A following clean `key[3]` press yields `bits = 2'd3`.
- Six separate presses, then `clear`: `pw_length` reads 1, 2, 3, 4, 4, 4, then 0 on the cycle after `clear`.
- `enter` pressed while `key[1]` is held: exactly one `compare` pulse; `bits` and `pw_length` unaffected.
- Auto-repeat build, `key[0]` held 40 cycles: first strobe at 7 cycles, then one every 8 cycles. `reset` asserted mid-hold returns all outputs to 0 on the next edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared widths, digit FSM state type and the one-hot to
// digit-code helper used by the keypad encoder.
package keypad_pkg;

  localparam int KEY_CODE_W = 2;
  localparam int NUM_KEYS   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LOCKOUT = 2'd2
  } state_e;

  // Index of the highest set bit; callers only use it when exactly one bit is set.
  function automatic logic [KEY_CODE_W-1:0] onehot_to_code(input logic [NUM_KEYS-1:0] onehot);
    logic [KEY_CODE_W-1:0] code;
    code = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (onehot[i]) code = KEY_CODE_W'(i);
    end
    return code;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: one button line. A 2-FF synchronizer followed by a
// debouncer whose output level only follows the synchronized input after it
// has disagreed for DEBOUNCE_CYCLES consecutive cycles.
module keypad_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("keypad_debounce: DEBOUNCE_CYCLES must be at least 2");
  end

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count consecutive disagreeing samples; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer flops, debounced level and counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/keypad_encoder.sv
// keypad_encoder: debounces four digit buttons and an enter button, emits
// one input_value strobe per accepted digit with its code on bits, a
// compare pulse per enter press, and a saturating digit count.
// Optional feature macro: KEYPAD_ENCODER_AUTOREPEAT_EN (re-strobe a held key
// every REPEAT_CYCLES cycles).
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_DIGITS      = 4,
  parameter int REPEAT_CYCLES   = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   key,
  input  logic                  enter,
  input  logic                  clear,
  output logic                  input_value,
  output logic [KEY_CODE_W-1:0] bits,
  output logic                  compare,
  output logic [2:0]            pw_length
);

  localparam logic [2:0] MAX_LEN = 3'(MAX_DIGITS);

  if (MAX_DIGITS < 1 || MAX_DIGITS > 7) begin : g_bad_max_digits
    $error("keypad_encoder: MAX_DIGITS must be in 1..7");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("keypad_encoder: REPEAT_CYCLES must be at least 1");
  end

  logic [NUM_KEYS-1:0]   key_db;
  logic                  enter_db;
  logic [2:0]            n_high;

  state_e                state_q;
  state_e                state_d;
  logic                  strobe_d;
  logic                  input_value_q;
  logic [KEY_CODE_W-1:0] bits_q;
  logic [KEY_CODE_W-1:0] bits_d;
  logic                  enter_prev_q;
  logic                  compare_q;
  logic                  compare_d;
  logic [2:0]            pw_length_q;
  logic [2:0]            pw_length_d;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key_db
    keypad_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_db (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (key[g]),
      .level_o(key_db[g])
    );
  end

  keypad_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_enter_db (
    .clk    (clk),
    .reset  (reset),
    .raw_i  (enter),
    .level_o(enter_db)
  );

  assign n_high = 3'($countones(key_db));

`ifdef KEYPAD_ENCODER_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_q;
  logic [REP_W-1:0] rep_d;
`endif

  // Digit FSM next state, strobe and code selection.
  always_comb begin
    state_d  = state_q;
    strobe_d = 1'b0;
    bits_d   = bits_q;
`ifdef KEYPAD_ENCODER_AUTOREPEAT_EN
    rep_d    = rep_q;
`endif
    case (state_q)
      IDLE: begin
        if (n_high == 3'd1) begin
          strobe_d = 1'b1;
          bits_d   = onehot_to_code(key_db);
          state_d  = PRESSED;
`ifdef KEYPAD_ENCODER_AUTOREPEAT_EN
          rep_d    = '0;
`endif
        end else if (n_high >= 3'd2) begin
          state_d = LOCKOUT;
        end
      end
      PRESSED: begin
        if (n_high == 3'd0) begin
          state_d = IDLE;
        end else if (n_high >= 3'd2) begin
          state_d = LOCKOUT;
        end
`ifdef KEYPAD_ENCODER_AUTOREPEAT_EN
        else if (rep_q == REP_LAST) begin
          strobe_d = 1'b1;
          rep_d    = '0;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      LOCKOUT: begin
        if (n_high == 3'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Enter edge detect and saturating digit count; clear wins over the old count.
  always_comb begin
    compare_d   = enter_db & ~enter_prev_q;
    pw_length_d = pw_length_q;
    if (clear) begin
      pw_length_d = strobe_d ? 3'd1 : 3'd0;
    end else if (strobe_d && (pw_length_q < MAX_LEN)) begin
      pw_length_d = pw_length_q + 3'd1;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      input_value_q <= 1'b0;
      bits_q        <= '0;
      enter_prev_q  <= 1'b0;
      compare_q     <= 1'b0;
      pw_length_q   <= '0;
`ifdef KEYPAD_ENCODER_AUTOREPEAT_EN
      rep_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      input_value_q <= strobe_d;
      bits_q        <= bits_d;
      enter_prev_q  <= enter_db;
      compare_q     <= compare_d;
      pw_length_q   <= pw_length_d;
`ifdef KEYPAD_ENCODER_AUTOREPEAT_EN
      rep_q         <= rep_d;
`endif
    end
  end

  assign input_value = input_value_q;
  assign bits        = bits_q;
  assign compare     = compare_q;
  assign pw_length   = pw_length_q;

endmodule
